oric_audio_mixer: RTL and testbench
===================================

// Module: oric_audio_mixer
// PURPOSE
//  Audio back-end between the Oric core's PSG outputs and the AUDIO_L/AUDIO_R top-level outputs.
//  - Samples the three 8-bit PSG channels and the 10-bit mono mix at a fixed rate.
//  - Applies the stereo matrix selected from the OSD.
//  - Runs a shared, time-multiplexed one-pole low-pass IIR over L and R.
//  - Presents registered 16-bit unsigned samples with a valid strobe.
// PARAMETERS
//  CLK_DIV     256  clk_sys cycles per audio sample; valid range 8..65535
//  FILT_SHIFT  2    IIR coefficient 2^-FILT_SHIFT; 0 = filter bypass (y = x); valid range 0..8
// PORTS
//  clk_sys       in   1   system clock; the only clock
//  reset_n       in   1   asynchronous, active-low reset
//  psg_a         in   8   PSG channel A, unsigned
//  psg_b         in   8   PSG channel B, unsigned
//  psg_c         in   8   PSG channel C, unsigned
//  psg_mono      in   10  PSG summed output, unsigned
//  stereo        in   2   00/11 mono, 01 ABC, 10 ACB
//  tape_out      in   1   cassette output bit (used only with AUDIO_TAPE_MIX_EN)
//  audio_l       out  16  left sample, unsigned
//  audio_r       out  16  right sample, unsigned
//  sample_valid  out  1   one-cycle pulse when audio_l and audio_r update
// BEHAVIOUR
//  - Reset (async assert, sync release): divider=0, FSM=IDLE, accumulators=0, audio_l=audio_r=0, sample_valid=0.
//  - Divider: counts 0..CLK_DIV-1, then wraps. The wrap cycle raises tick for one cycle.
//  - FSM: IDLE -tick-> CAP -> MIX -> FILT_L -> FILT_R -> OUT -> IDLE.
//    - Every state except IDLE lasts exactly 1 cycle.
//    - A tick arriving outside IDLE cannot happen, because CLK_DIV>=8.
//  - CAP: registers psg_a/b/c, psg_mono, stereo and tape_out together. Input changes take effect at the next CAP only.
//  - MIX (9-bit sums, zero-extended):
//    - 01: xl = (A+B)<<7, xr = (C+B)<<7
//    - 10: xl = (A+C)<<7, xr = (C+B)<<7
//    - 00/11: xl = xr = psg_mono<<6
//  - Filter state: acc_l, acc_r are 20 bits (16.4 unsigned).
//  - FILT_L: d = signed(x<<4) - signed(acc_l), 21 bits; acc_l += d >>> FILT_SHIFT (arithmetic shift). One shared subtract/shift datapath.
//  - FILT_R: same operation using xr and acc_r.
//  - FILT_SHIFT=0: acc = x<<4 exactly. No overshoot is possible; acc never exceeds x_max<<4.
//  - OUT: audio_l = acc_l[19:4], audio_r = acc_r[19:4], sample_valid=1.
//  - Latency: tick to sample_valid is 5 cycles. Outputs hold their value between updates.
//  - Full-scale inputs: 255+255 = 510; 510<<7 = 0xFF00. No overflow.
//  - Mono full scale: 1023<<6 = 0xFFC0.
//  - reset_n asserted mid-sequence aborts the FSM and clears all state. No partial sample is emitted.
// CONFIGURATION
//  AUDIO_TAPE_MIX_EN defined:
//  - In MIX, when captured tape_out=1, add 16'h1000 to both xl and xr.
//  - The addition saturates at 16'hFFFF, using a 17-bit add then clamp.
//  AUDIO_TAPE_MIX_EN undefined:
//  - tape_out is ignored and no tape logic is synthesised.
// STRUCTURE
//  - Package oric_audio_pkg:
//    - typedef enum FSM states: IDLE, CAP, MIX, FILT_L, FILT_R, OUT.
//    - localparam stereo codes: ST_MONO=2'b00, ST_ABC=2'b01, ST_ACB=2'b10.
//    - localparam TAPE_LEVEL=16'h1000.
//  - One sub-module, oric_audio_iir_step, purely combinational:
//    - Inputs: x[15:0], acc[19:0], shift.
//    - Output: acc_next[19:0].
//    - Instantiated once and multiplexed between L and R.
// TESTING
//  1. Reset then idle (CLK_DIV=8, FILT_SHIFT=0) -> audio_l=audio_r=0; first sample_valid exactly 5 cycles after the first tick.
//  2. stereo=01, A=8'h10, B=8'h20, C=8'h30, FILT_SHIFT=0 -> audio_l=16'h1800, audio_r=16'h2800 on the first valid.
//  3. stereo=00, psg_mono=10'h3FF, FILT_SHIFT=0 -> audio_l=audio_r=16'hFFC0. stereo=10, A=C=8'hFF -> audio_l=16'hFF00.
//  4. FILT_SHIFT=1, step from 0 to xl=16'h8000 -> audio_l sequence 16'h4000, 16'h6000, 16'h7000 on successive valids.
//  5. reset_n pulsed low during FILT_L -> no sample_valid for that tick; outputs=0 until the next full sequence.
//  6. AUDIO_TAPE_MIX_EN defined, stereo=10, A=C=8'hFF, tape_out=1 -> audio_l=16'hFFFF (saturated); tape_out=0 -> 16'hFF00.

Source files
------------

// File: rtl/oric_audio_pkg.sv
// oric_audio_pkg: shared FSM states, stereo codes and tape level for the Oric audio mixer.
package oric_audio_pkg;
  typedef enum logic [2:0] {IDLE, CAP, MIX, FILT_L, FILT_R, OUT} state_t;
  localparam logic [1:0] ST_MONO = 2'b00;
  localparam logic [1:0] ST_ABC = 2'b01;
  localparam logic [1:0] ST_ACB = 2'b10;
  localparam logic [15:0] TAPE_LEVEL = 16'h1000;
endpackage

// File: rtl/oric_audio_iir_step.sv
// oric_audio_iir_step: one-pole low-pass step, acc += (x<<4 - acc) >>> shift, on 16.4 unsigned state.
module oric_audio_iir_step
  import oric_audio_pkg::*;
(
  input  logic [15:0] x,
  input  logic [19:0] acc,
  input  logic [3:0]  shift,
  output logic [19:0] acc_next
);
  logic signed [20:0] d;
  logic signed [20:0] s;
  assign d = $signed({1'b0, x, 4'b0}) - $signed({1'b0, acc});
  assign s = d >>> shift;
  // The result always lies between acc and x<<4, so truncating to 20 bits is exact.
  assign acc_next = 20'($signed({1'b0, acc}) + s);
endmodule

// File: rtl/oric_audio_mixer.sv
// oric_audio_mixer: samples PSG outputs, applies the stereo matrix and a shared L/R IIR low-pass.
// Optional cassette mix into both channels when AUDIO_TAPE_MIX_EN is defined.
module oric_audio_mixer
  import oric_audio_pkg::*;
#(
  parameter int CLK_DIV = 256,
  parameter int FILT_SHIFT = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  psg_a,
  input  logic [7:0]  psg_b,
  input  logic [7:0]  psg_c,
  input  logic [9:0]  psg_mono,
  input  logic [1:0]  stereo,
  input  logic        tape_out,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_valid
);
  state_t state, state_nx;
  logic [15:0] div;
  logic tick, cap_en, mix_en, filt_l_en, filt_r_en, stereo_mode;
  logic [7:0] a_q, b_q, c_q;
  logic [9:0] mono_q;
  logic [1:0] st_q;
  logic [8:0] sum_l, sum_r;
  logic [15:0] mix_l, mix_r, xl_in, xr_in, xl, xr;
  logic [19:0] acc_l, acc_r, acc_nx;
  assign tick = div == 16'(CLK_DIV - 1);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) div <= '0;
    else div <= tick ? '0 : div + 16'd1;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = tick ? CAP : IDLE;
      CAP:     state_nx = MIX;
      MIX:     state_nx = FILT_L;
      FILT_L:  state_nx = FILT_R;
      FILT_R:  state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cap_en = state == CAP;
    mix_en = state == MIX;
    filt_l_en = state == FILT_L;
    filt_r_en = state == FILT_R;
  end
  always_comb begin
    sum_l = {1'b0, a_q} + {1'b0, st_q == ST_ACB ? c_q : b_q};
    sum_r = {1'b0, c_q} + {1'b0, b_q};
    stereo_mode = st_q == ST_ABC || st_q == ST_ACB;
    mix_l = stereo_mode ? {sum_l, 7'b0} : {mono_q, 6'b0};
    mix_r = stereo_mode ? {sum_r, 7'b0} : {mono_q, 6'b0};
  end
`ifdef AUDIO_TAPE_MIX_EN
  logic tape_q;
  logic [16:0] tape_l, tape_r;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) tape_q <= 1'b0;
    else if (cap_en) tape_q <= tape_out;
  assign tape_l = {1'b0, mix_l} + {1'b0, tape_q ? TAPE_LEVEL : 16'h0};
  assign tape_r = {1'b0, mix_r} + {1'b0, tape_q ? TAPE_LEVEL : 16'h0};
  assign xl_in = tape_l[16] ? 16'hFFFF : tape_l[15:0];
  assign xr_in = tape_r[16] ? 16'hFFFF : tape_r[15:0];
`else
  logic unused_tape;
  assign unused_tape = tape_out;
  assign xl_in = mix_l;
  assign xr_in = mix_r;
`endif
  oric_audio_iir_step iir (
    .x(filt_r_en ? xr : xl),
    .acc(filt_r_en ? acc_r : acc_l),
    .shift(4'(FILT_SHIFT)),
    .acc_next(acc_nx)
  );
  // Outputs load on the FILT_R edge so they are presented, with the strobe, during OUT.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      {a_q, b_q, c_q, mono_q, st_q} <= '0;
      {xl, xr, acc_l, acc_r} <= '0;
      {audio_l, audio_r, sample_valid} <= '0;
    end else begin
      if (cap_en) {a_q, b_q, c_q, mono_q, st_q} <= {psg_a, psg_b, psg_c, psg_mono, stereo};
      if (mix_en) {xl, xr} <= {xl_in, xr_in};
      if (filt_l_en) acc_l <= acc_nx;
      if (filt_r_en) {acc_r, audio_l, audio_r} <= {acc_nx, acc_l[19:4], acc_nx[19:4]};
      sample_valid <= filt_r_en;
    end
endmodule

// File: tb/tb_oric_audio_mixer.sv
// tb_oric_audio_mixer: two mixers (FILT_SHIFT 0 and 1, CLK_DIV 8) checked against a sample-level model.
module tb_oric_audio_mixer;
  logic clk = 1'b0, rst_n = 1'b0, tape = 1'b0, chk_on = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic [9:0] mono = '0;
  logic [1:0] st = '0;
  logic [15:0] l0, r0, l1, r1;
  logic v0, v1;
  int tests = 0, fails = 0, n;
  int e = 0;
  int acc_l[2], acc_r[2], pl[2], pr[2], el[2], er[2];
  always #5 clk = ~clk;
  oric_audio_mixer #(.CLK_DIV(8), .FILT_SHIFT(0)) dut0 (
    .clk_sys(clk), .reset_n(rst_n), .psg_a(a), .psg_b(b), .psg_c(c), .psg_mono(mono),
    .stereo(st), .tape_out(tape), .audio_l(l0), .audio_r(r0), .sample_valid(v0));
  oric_audio_mixer #(.CLK_DIV(8), .FILT_SHIFT(1)) dut1 (
    .clk_sys(clk), .reset_n(rst_n), .psg_a(a), .psg_b(b), .psg_c(c), .psg_mono(mono),
    .stereo(st), .tape_out(tape), .audio_l(l1), .audio_r(r1), .sample_valid(v1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int iir(input int acc, input int x, input int s);
    return acc + ((x * 16 - acc) >>> s);
  endfunction
  // Model: sample taken 9 edges after release then every 8; result visible 3 edges later.
  always @(posedge clk or negedge rst_n) begin : model
    int xl, xr;
    if (!rst_n) begin
      e = 0;
      for (int d = 0; d < 2; d++) {acc_l[d], acc_r[d], pl[d], pr[d], el[d], er[d]} = '0;
    end else begin
      e++;
      if (e >= 9 && e % 8 == 1) begin
        xl = st == 2'b01 ? (a + b) * 128 : st == 2'b10 ? (a + c) * 128 : mono * 64;
        xr = (st == 2'b01 || st == 2'b10) ? (c + b) * 128 : mono * 64;
`ifdef AUDIO_TAPE_MIX_EN
        if (tape) begin
          xl = xl + 4096 > 65535 ? 65535 : xl + 4096;
          xr = xr + 4096 > 65535 ? 65535 : xr + 4096;
        end
`endif
        for (int d = 0; d < 2; d++) begin
          acc_l[d] = iir(acc_l[d], xl, d);
          acc_r[d] = iir(acc_r[d], xr, d);
          pl[d] = acc_l[d] / 16;
          pr[d] = acc_r[d] / 16;
        end
      end
      if (e >= 12 && e % 8 == 4) begin
        el = pl;
        er = pr;
      end
    end
  end
  always @(negedge clk) if (rst_n && chk_on) begin
    chk("valid0", 32'(v0), 32'(e >= 12 && e % 8 == 4));
    chk("valid1", 32'(v1), 32'(e >= 12 && e % 8 == 4));
    chk("l0", 32'(l0), el[0]);
    chk("r0", 32'(r0), er[0]);
    chk("l1", 32'(l1), el[1]);
    chk("r1", 32'(r1), er[1]);
  end
  task automatic start();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!v0 && cnt < 40);
    chk("valid_wait", 32'(v0), 1);
  endtask
  initial begin
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_l", 32'(l0), 0);
    chk("rst_valid", 32'(v0), 0);
    rst_n = 1'b1;
    wait_valid(n);
    chk("first_latency", n, 12);
    chk("idle_l", 32'(l0), 0);
    chk("idle_r", 32'(r0), 0);
    {a, b, c, st} = {8'h10, 8'h20, 8'h30, 2'b01};
    start();
    wait_valid(n);
    chk("abc_l", 32'(l0), 32'h1800);
    chk("abc_r", 32'(r0), 32'h2800);
    chk("model_abc_l", el[0], 32'h1800);
    {mono, st} = {10'h3FF, 2'b00};
    start();
    wait_valid(n);
    chk("mono_l", 32'(l0), 32'hFFC0);
    chk("mono_r", 32'(r0), 32'hFFC0);
    {a, b, c, st} = {8'hFF, 8'h00, 8'hFF, 2'b10};
    start();
    wait_valid(n);
    chk("acb_l", 32'(l0), 32'hFF00);
    chk("acb_r", 32'(r0), 32'h7F80);
    {a, b, c, st} = {8'h80, 8'h80, 8'h80, 2'b01};
    start();
    wait_valid(n);
    chk("step1_l", 32'(l1), 32'h4000);
    chk("model_step1", el[1], 32'h4000);
    chk("step0_l", 32'(l0), 32'h8000);
    wait_valid(n);
    chk("step2_l", 32'(l1), 32'h6000);
    wait_valid(n);
    chk("step3_l", 32'(l1), 32'h7000);
    chk("model_step3", el[1], 32'h7000);
    {a, b, c, st} = {8'h10, 8'h20, 8'h30, 2'b01};
    start();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("abort_valid", 32'(v0), 0);
      chk("abort_l", 32'(l1), 0);
    end
    wait_valid(n);
    chk("after_abort_l", 32'(l0), 32'h1800);
`ifdef AUDIO_TAPE_MIX_EN
    {a, b, c, st, tape} = {8'hFF, 8'h00, 8'hFF, 2'b10, 1'b1};
    start();
    wait_valid(n);
    chk("tape_sat_l", 32'(l0), 32'hFFFF);
    chk("tape_r", 32'(r0), 32'h8F80);
    tape = 1'b0;
    start();
    wait_valid(n);
    chk("tape_off_l", 32'(l0), 32'hFF00);
`endif
    start();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        mono = 10'($urandom);
        st = 2'($urandom);
        tape = 1'($urandom);
      end
      if (i == 400) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
